// File: rtl/mc_ctrl_pkg.sv
// Package mc_ctrl_pkg
//   Shared encodings for the multicycle MIPS controller: FSM state codes,
//   opcode/func constants, ALU control codes and datapath select encodings.
//   Also holds a helper that resolves the conditional branch decision.
package mc_ctrl_pkg;

  typedef logic [2:0] state_t;

  // FSM state encodings (also exported on the debug state port)
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type func codes (IR[5:0])
  localparam logic [5:0] FUNC_SLL = 6'b000000;
  localparam logic [5:0] FUNC_SRL = 6'b000010;
  localparam logic [5:0] FUNC_SRA = 6'b000011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_XOR = 6'b100110;

  // ALU control codes
  localparam logic [3:0] ALUC_ADD   = 4'b0000;
  localparam logic [3:0] ALUC_SUB   = 4'b0100;
  localparam logic [3:0] ALUC_AND   = 4'b0001;
  localparam logic [3:0] ALUC_OR    = 4'b0101;
  localparam logic [3:0] ALUC_XOR   = 4'b0010;
  localparam logic [3:0] ALUC_LUI   = 4'b0110;
  localparam logic [3:0] ALUC_SLL   = 4'b0011;
  localparam logic [3:0] ALUC_SRL   = 4'b0111;
  localparam logic [3:0] ALUC_SRA   = 4'b1111;
  localparam logic [3:0] ALUC_COUNT = 4'b1000;

  // Datapath select encodings
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;
  localparam logic [1:0] SRC_A_PC      = 2'b00;
  localparam logic [1:0] SRC_A_RS      = 2'b01;
  localparam logic [1:0] SRC_A_SHAMT   = 2'b10;
  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;
  localparam logic [1:0] REG_DST_RT    = 2'b00;
  localparam logic [1:0] REG_DST_RD    = 2'b01;
  localparam logic [1:0] REG_DST_RA    = 2'b10;
  localparam logic [1:0] M2R_ALUOUT    = 2'b00;
  localparam logic [1:0] M2R_MDR       = 2'b01;
  localparam logic [1:0] M2R_PC        = 2'b10;

  // beq takes the branch on a zero difference, bne on a non-zero one
  function automatic logic branch_taken(input logic is_beq, input logic is_zero);
    if (is_beq) begin
      return is_zero;
    end else begin
      return ~is_zero;
    end
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Module alu_op_decode
//   Combinational op/func decoder for the multicycle controller.
//   Ports:
//     op, func  in  6  opcode and function fields of the IR
//     aluc      out 4  ALU control code for the EXE step of this instruction
//     is_rtype  out 1  op is the R-type opcode
//     is_shift  out 1  R-type shift (sll/srl/sra): ALU A operand is shamt
//     legal     out 1  op/func combination is implemented (includes j/jal/jr)
module alu_op_decode
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] COUNT_FUNC = 6'b111111
) (
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [3:0] aluc,
  output logic       is_rtype,
  output logic       is_shift,
  output logic       legal
);

  // Instruction decode; COUNT_FUNC is checked first because it is a parameter
  always_comb begin
    aluc     = ALUC_ADD;
    is_rtype = 1'b0;
    is_shift = 1'b0;
    legal    = 1'b0;
    case (op)
      OP_RTYPE: begin
        is_rtype = 1'b1;
        if (func == COUNT_FUNC) begin
          aluc  = ALUC_COUNT;
          legal = 1'b1;
        end else begin
          case (func)
            FUNC_ADD: begin aluc = ALUC_ADD; legal = 1'b1; end
            FUNC_SUB: begin aluc = ALUC_SUB; legal = 1'b1; end
            FUNC_AND: begin aluc = ALUC_AND; legal = 1'b1; end
            FUNC_OR:  begin aluc = ALUC_OR;  legal = 1'b1; end
            FUNC_XOR: begin aluc = ALUC_XOR; legal = 1'b1; end
            FUNC_SLL: begin aluc = ALUC_SLL; is_shift = 1'b1; legal = 1'b1; end
            FUNC_SRL: begin aluc = ALUC_SRL; is_shift = 1'b1; legal = 1'b1; end
            FUNC_SRA: begin aluc = ALUC_SRA; is_shift = 1'b1; legal = 1'b1; end
            FUNC_JR:  legal = 1'b1;
            default:  legal = 1'b0;
          endcase
        end
      end
      OP_J, OP_JAL:          legal = 1'b1;
      OP_BEQ, OP_BNE:        begin aluc = ALUC_SUB; legal = 1'b1; end
      OP_ADDI, OP_LW, OP_SW: begin aluc = ALUC_ADD; legal = 1'b1; end
      OP_ANDI:               begin aluc = ALUC_AND; legal = 1'b1; end
      OP_ORI:                begin aluc = ALUC_OR;  legal = 1'b1; end
      OP_XORI:               begin aluc = ALUC_XOR; legal = 1'b1; end
      OP_LUI:                begin aluc = ALUC_LUI; legal = 1'b1; end
      default:               legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Module mc_control_unit
//   Multicycle MIPS controller: sequences IF/ID/EXE/MEM/WB, drives ALU
//   control and datapath selects, and handshakes with the unified memory.
//   Ports:
//     clock, reset          rising-edge clock, synchronous active-high reset
//     op, func              IR[31:26], IR[5:0] (stable from ID until next IF)
//     is_zero               ALU result zero flag (combinational)
//     mem_ack               memory completes the current request this cycle
//     mem_req, mem_we, iord memory request, write enable, address select
//     ir_write, pc_write    IR/MDR load and PC load strobes
//     pc_src, alu_src_a, alu_src_b, ext_sign, aluc   datapath/ALU controls
//     reg_write, reg_dst, mem_to_reg                 register write-back controls
//     illegal_op            one-cycle pulse on an undecodable instruction
//     state                 current FSM state (debug)
//   Outputs are decoded from the state register (Mealy on is_zero/mem_ack)
//   and forced to zero while reset is high.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] COUNT_FUNC = 6'b111111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       is_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic [3:0] aluc,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal_op,
  output logic [2:0] state
);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] aluc_dec_s;
  logic       is_rtype_s;
  logic       is_shift_s;
  logic       legal_s;
  logic       is_jr_s;
  logic       is_lw_s;
  logic       is_sw_s;
  logic       is_addi_s;
  logic       is_beq_s;
  logic       is_bne_s;

  alu_op_decode #(
    .COUNT_FUNC(COUNT_FUNC)
  ) u_alu_op_decode (
    .op      (op),
    .func    (func),
    .aluc    (aluc_dec_s),
    .is_rtype(is_rtype_s),
    .is_shift(is_shift_s),
    .legal   (legal_s)
  );

  assign is_jr_s   = is_rtype_s && (func == FUNC_JR);
  assign is_lw_s   = (op == OP_LW);
  assign is_sw_s   = (op == OP_SW);
  assign is_addi_s = (op == OP_ADDI);
  assign is_beq_s  = (op == OP_BEQ);
  assign is_bne_s  = (op == OP_BNE);
  assign state     = state_r;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode
  always_comb begin
    next_state_s = S_IF;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RT;
    ext_sign     = 1'b0;
    aluc         = ALUC_ADD;
    reg_write    = 1'b0;
    reg_dst      = REG_DST_RT;
    mem_to_reg   = M2R_ALUOUT;
    illegal_op   = 1'b0;
    if (reset) begin
      // Everything stays at its zero default; any pending request is dropped
      next_state_s = S_IF;
    end else begin
      case (state_r)
        S_IF: begin
          mem_req   = 1'b1;
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_FOUR;
          if (mem_ack) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            next_state_s = S_ID;
          end else begin
            next_state_s = S_IF;
          end
        end
        S_ID: begin
          // Branch target PC+4+(imm<<2) is computed speculatively into ALUOut
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_IMM_SH2;
          ext_sign  = 1'b1;
          if (!legal_s) begin
            illegal_op   = 1'b1;
            next_state_s = S_IF;
          end else if ((op == OP_J) || (op == OP_JAL)) begin
            pc_write     = 1'b1;
            pc_src       = PC_SRC_JUMP;
            next_state_s = S_IF;
            if (op == OP_JAL) begin
              reg_write  = 1'b1;
              reg_dst    = REG_DST_RA;
              mem_to_reg = M2R_PC;
            end else begin
              reg_write  = 1'b0;
            end
          end else if (is_jr_s) begin
            pc_write     = 1'b1;
            pc_src       = PC_SRC_RS;
            next_state_s = S_IF;
          end else begin
            next_state_s = S_EXE;
          end
        end
        S_EXE: begin
          if (is_rtype_s) begin
            alu_src_a    = is_shift_s ? SRC_A_SHAMT : SRC_A_RS;
            alu_src_b    = SRC_B_RT;
            aluc         = aluc_dec_s;
            next_state_s = S_WB;
          end else if (is_beq_s || is_bne_s) begin
            alu_src_a    = SRC_A_RS;
            alu_src_b    = SRC_B_RT;
            aluc         = ALUC_SUB;
            pc_src       = PC_SRC_ALUOUT;
            pc_write     = branch_taken(is_beq_s, is_zero);
            next_state_s = S_IF;
          end else begin
            // Immediate forms: arithmetic/address sign-extends, logical/lui zero-extends
            alu_src_a    = SRC_A_RS;
            alu_src_b    = SRC_B_IMM;
            ext_sign     = is_addi_s || is_lw_s || is_sw_s;
            aluc         = aluc_dec_s;
            next_state_s = (is_lw_s || is_sw_s) ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_sw_s;
          if (mem_ack) begin
            next_state_s = is_sw_s ? S_IF : S_WB;
          end else begin
            next_state_s = S_MEM;
          end
        end
        S_WB: begin
          reg_write    = 1'b1;
          reg_dst      = is_rtype_s ? REG_DST_RD : REG_DST_RT;
          mem_to_reg   = is_lw_s ? M2R_MDR : M2R_ALUOUT;
          next_state_s = S_IF;
        end
        default: next_state_s = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;
  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       is_zero, mem_ack;
  logic       mem_req, mem_we, iord, ir_write, pc_write, ext_sign;
  logic [1:0] pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
  logic [3:0] aluc;
  logic       reg_write, illegal_op;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  mc_control_unit dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .is_zero(is_zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sign(ext_sign),
    .aluc(aluc), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    int         if_wait;
    int         mem_wait;
    int         cycles;
    logic [3:0] exe_aluc;
    logic [1:0] exe_a;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       rw;
    logic [1:0] dst;
    logic [1:0] m2r;
    int         ill;
    int         mem_cyc;
    logic       mem_we;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                              input int iw, input int mw, input int cy,
                              input logic [3:0] ea, input logic [1:0] ex_a,
                              input logic pw, input logic [1:0] ps, input logic r,
                              input logic [1:0] d, input logic [1:0] m, input int il,
                              input int mc, input logic we);
    vec_t v;
    v.op = o; v.func = f; v.zero = z; v.if_wait = iw; v.mem_wait = mw; v.cycles = cy;
    v.exe_aluc = ea; v.exe_a = ex_a; v.pcw = pw; v.pcsrc = ps; v.rw = r;
    v.dst = d; v.m2r = m; v.ill = il; v.mem_cyc = mc; v.mem_we = we;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  // Runs one instruction from IF back to IF, applying the requested memory waits
  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, ifc = 0, memc = 0, mcyc = 0, ill = 0, irw = 0;
    bit left = 1'b0, done = 1'b0;
    logic [3:0] e_aluc = 4'b1001;
    logic [1:0] e_a = 2'b11;
    logic we_or = 1'b0, l_pcw = 1'b0, l_rw = 1'b0;
    logic [1:0] l_pcsrc = 2'b00, l_dst = 2'b00, l_m2r = 2'b00;
    op = v.op; func = v.func; is_zero = v.zero;
    while (!done && cyc < 40) begin
      mem_ack = ((state == 3'd0 && ifc < v.if_wait) || (state == 3'd3 && memc < v.mem_wait)) ? 1'b0 : 1'b1;
      #1;
      if (state == 3'd0 && !mem_ack) ifc++;
      if (state == 3'd3 && !mem_ack) memc++;
      if (state != 3'd0) left = 1'b1;
      if (state == 3'd2) begin e_aluc = aluc; e_a = alu_src_a; end
      if (state == 3'd3) begin
        if (mem_req) mcyc++;
        we_or = we_or | mem_we;
      end
      if (illegal_op) ill++;
      if (ir_write) irw++;
      l_pcw = pc_write; l_pcsrc = pc_src; l_rw = reg_write; l_dst = reg_dst; l_m2r = mem_to_reg;
      @(negedge clock);
      cyc++;
      if (left && state == 3'd0) done = 1'b1;
    end
    chk("completed", idx, int'(done), 1);
    chk("cycles", idx, cyc, v.cycles);
    chk("exe_aluc", idx, int'(e_aluc), int'(v.exe_aluc));
    chk("exe_alu_src_a", idx, int'(e_a), int'(v.exe_a));
    chk("last_pc_write", idx, int'(l_pcw), int'(v.pcw));
    chk("last_pc_src", idx, int'(l_pcsrc), int'(v.pcsrc));
    chk("last_reg_write", idx, int'(l_rw), int'(v.rw));
    chk("last_reg_dst", idx, int'(l_dst), int'(v.dst));
    chk("last_mem_to_reg", idx, int'(l_m2r), int'(v.m2r));
    chk("illegal_pulses", idx, ill, v.ill);
    chk("mem_req_cycles", idx, mcyc, v.mem_cyc);
    chk("mem_we_seen", idx, int'(we_or), int'(v.mem_we));
    chk("ir_write_pulses", idx, irw, 1);
  endtask

  logic [2:0] exp_tr [5];

  initial begin
    // R-type ALU
    vecs.push_back(mk(6'b000000, 6'b100000, 1'b0, 0, 0, 4, 4'b0000, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0)); // add
    vecs.push_back(mk(6'b000000, 6'b100010, 1'b0, 0, 0, 4, 4'b0100, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0)); // sub
    vecs.push_back(mk(6'b000000, 6'b100100, 1'b0, 0, 0, 4, 4'b0001, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0)); // and
    vecs.push_back(mk(6'b000000, 6'b100101, 1'b0, 0, 0, 4, 4'b0101, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0)); // or
    vecs.push_back(mk(6'b000000, 6'b100110, 1'b0, 0, 0, 4, 4'b0010, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0)); // xor
    vecs.push_back(mk(6'b000000, 6'b000000, 1'b0, 0, 0, 4, 4'b0011, 2'b10, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0)); // sll
    vecs.push_back(mk(6'b000000, 6'b000010, 1'b0, 0, 0, 4, 4'b0111, 2'b10, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0)); // srl
    vecs.push_back(mk(6'b000000, 6'b000011, 1'b0, 0, 0, 4, 4'b1111, 2'b10, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0)); // sra
    vecs.push_back(mk(6'b000000, 6'b111111, 1'b0, 0, 0, 4, 4'b1000, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 0, 0, 1'b0)); // count
    // I-type ALU
    vecs.push_back(mk(6'b001000, 6'b000000, 1'b0, 0, 0, 4, 4'b0000, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0)); // addi
    vecs.push_back(mk(6'b001100, 6'b000000, 1'b0, 0, 0, 4, 4'b0001, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0)); // andi
    vecs.push_back(mk(6'b001101, 6'b000000, 1'b0, 0, 0, 4, 4'b0101, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0)); // ori
    vecs.push_back(mk(6'b001110, 6'b000000, 1'b0, 0, 0, 4, 4'b0010, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0)); // xori
    vecs.push_back(mk(6'b001111, 6'b000000, 1'b0, 0, 0, 4, 4'b0110, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0)); // lui
    // Memory: lw with 3 MEM wait cycles, sw with 2 IF wait cycles, lw zero-wait
    vecs.push_back(mk(6'b100011, 6'b000000, 1'b0, 0, 3, 8, 4'b0000, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 0, 4, 1'b0)); // lw
    vecs.push_back(mk(6'b101011, 6'b000000, 1'b0, 2, 0, 6, 4'b0000, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 0, 1, 1'b1)); // sw
    vecs.push_back(mk(6'b100011, 6'b000000, 1'b0, 0, 0, 5, 4'b0000, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 0, 1, 1'b0)); // lw
    // Branches
    vecs.push_back(mk(6'b000100, 6'b000000, 1'b1, 0, 0, 3, 4'b0100, 2'b01, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0)); // beq taken
    vecs.push_back(mk(6'b000100, 6'b000000, 1'b0, 0, 0, 3, 4'b0100, 2'b01, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0)); // beq not
    vecs.push_back(mk(6'b000101, 6'b000000, 1'b1, 0, 0, 3, 4'b0100, 2'b01, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0)); // bne not
    vecs.push_back(mk(6'b000101, 6'b000000, 1'b0, 0, 0, 3, 4'b0100, 2'b01, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0)); // bne taken
    // Jumps (EXE never reached: sentinel captures stay)
    vecs.push_back(mk(6'b000010, 6'b000000, 1'b0, 0, 0, 2, 4'b1001, 2'b11, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0)); // j
    vecs.push_back(mk(6'b000011, 6'b000000, 1'b0, 0, 0, 2, 4'b1001, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 0, 0, 1'b0)); // jal
    vecs.push_back(mk(6'b000000, 6'b001000, 1'b0, 0, 0, 2, 4'b1001, 2'b11, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0)); // jr
    // Illegal op and illegal func
    vecs.push_back(mk(6'b111110, 6'b000000, 1'b0, 0, 0, 2, 4'b1001, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1, 0, 1'b0));
    vecs.push_back(mk(6'b000000, 6'b111110, 1'b0, 0, 0, 2, 4'b1001, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1, 0, 1'b0));

    reset = 1'b1; mem_ack = 1'b1; op = 6'd0; func = 6'd0; is_zero = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_outputs", 0, int'({mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
        alu_src_b, ext_sign, aluc, reg_write, reg_dst, mem_to_reg, illegal_op}), 0);
    chk("reset_state", 0, int'(state), 0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // add: explicit state trace 0,1,2,4,0 with immediate acks
    exp_tr[0] = 3'd0; exp_tr[1] = 3'd1; exp_tr[2] = 3'd2; exp_tr[3] = 3'd4; exp_tr[4] = 3'd0;
    op = 6'b000000; func = 6'b100000; mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("add_trace", i, int'(state), int'(exp_tr[i]));
      if (i < 4) @(negedge clock);
    end

    // Reset during an IF wait drops the request; ack during reset is ignored
    mem_ack = 1'b0;
    @(negedge clock); #1;
    chk("if_wait_state", 0, int'(state), 0);
    chk("if_wait_req", 0, int'(mem_req), 1);
    reset = 1'b1; mem_ack = 1'b1; #1;
    chk("rst_req", 0, int'(mem_req), 0);
    chk("rst_strobes", 0, int'({ir_write, pc_write}), 0);
    @(negedge clock); #1;
    chk("rst_state", 1, int'(state), 0);
    chk("rst_req", 1, int'(mem_req), 0);
    reset = 1'b0; mem_ack = 1'b0; #1;
    chk("refetch_req", 0, int'(mem_req), 1);
    chk("refetch_iord", 0, int'(iord), 0);
    mem_ack = 1'b1; #1;
    chk("refetch_irw", 0, int'(ir_write), 1);
    @(negedge clock); #1;
    chk("refetch_state", 0, int'(state), 1);
    for (int k = 0; k < 10 && state != 3'd0; k++) @(negedge clock);
    chk("refetch_done", 0, int'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
